pmu_mode_arbiter: RTL and testbench
===================================

PMU_MODE_ARBITER -- requirements
Module: pmu_mode_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 4: number of power-mode requesters (1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the hold-off and timeout counters.
REQ-003 SHALL have port perm_clk, input, 1 bit: clock.
REQ-004 SHALL have port perm_rstb, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port perm_vote_valid, input, NB_REQ bits: per-requester vote valid.
REQ-006 SHALL have port perm_vote_mode, input, 2*NB_REQ bits: per-requester mode, requester i at bits [2i+1:2i], using the PMU mode encoding.
REQ-007 SHALL have port perm_holdoff_limit, input, CNT_WIDTH bits: downgrade hold-off in cycles.
REQ-008 SHALL have port perm_timeout_limit, input, CNT_WIDTH bits: acknowledge timeout in cycles; 0 disables the timeout.
REQ-009 SHALL have ports perm_sleep_req, perm_stdby_req, perm_active_req and perm_measure_req, each output, 1 bit: level requests to the PMU.
REQ-010 SHALL have ports perm_sleep_ack, perm_stdby_ack, perm_active_ack and perm_measure_ack, each input, 1 bit: PMU mode acknowledges.
REQ-011 SHALL have port perm_granted_mode, output, 2 bits: last mode acknowledged by the PMU.
REQ-012 SHALL have port perm_busy, output, 1 bit: a transition is in hold-off or awaiting acknowledge.
REQ-013 SHALL have port perm_timeout_err, output, 1 bit: sticky timeout flag.
REQ-014 SHALL have port perm_err_clr, input, 1 bit: synchronous clear of perm_timeout_err.

Function
REQ-015 SHALL use the mode encoding DEEP_SLEEP=2'b11, STANDBY=2'b10, ACTIVE=2'b00, MEASURE=2'b01.
REQ-016 SHALL rank modes MEASURE(3) > ACTIVE(2) > STANDBY(1) > DEEP_SLEEP(0).
REQ-017 SHALL compute target as the highest-ranked mode among valid votes; with no valid vote, target = DEEP_SLEEP.
REQ-018 SHALL assert exactly one request output at all times: the mode being requested (in WAIT) or perm_granted_mode (otherwise).
REQ-019 SHALL implement FSM states IDLE, HOLD and WAIT.
REQ-020 IDLE SHALL behave as follows:
- target rank above granted -> WAIT next cycle (upgrade, no hold-off);
- target rank below granted with perm_holdoff_limit = 0 -> WAIT;
- target rank below granted with perm_holdoff_limit != 0 -> HOLD with counter cleared;
- target equal to granted -> stay in IDLE.
REQ-021 HOLD SHALL increment the counter each cycle and behave as follows:
- target change -> counter restarts at 0;
- target rank >= granted -> IDLE (or WAIT if strictly higher);
- counter reaching perm_holdoff_limit - 1 -> WAIT.
REQ-022 On entry to WAIT the block SHALL latch the target as the requested mode, clear the counter and assert the corresponding request the same cycle.
REQ-023 WAIT SHALL ignore target changes until it exits.
REQ-024 WAIT SHALL exit when the ack matching the requested mode is seen: perm_granted_mode <= requested mode next cycle, return to IDLE.
REQ-025 perm_busy SHALL equal (state != IDLE), registered with the state.
REQ-026 Counters SHALL saturate at all-ones and never wrap.
REQ-027 perm_err_clr asserted in the same cycle as a new timeout SHALL leave perm_timeout_err set (set wins).

Reset
REQ-028 While perm_rstb is low, outputs SHALL be:
- state IDLE, counter 0;
- perm_granted_mode = ACTIVE, perm_active_req = 1, other requests 0;
- perm_busy = 0, perm_timeout_err = 0.
REQ-029 Reset mid-WAIT or mid-HOLD SHALL abandon the transition with no further request pulse.

Configuration
REQ-030 With macro PMU_MODE_ARB_TIMEOUT_EN defined, WAIT SHALL treat perm_timeout_limit != 0 and counter = perm_timeout_limit as a timeout: set perm_timeout_err, return to IDLE, keep perm_granted_mode unchanged, and retry per REQ-020.
REQ-031 Without PMU_MODE_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, perm_timeout_err SHALL be tied to 0 and perm_err_clr SHALL be ignored; the port list SHALL be identical in both builds.

Structure
REQ-032 Package pmu_pkg SHALL hold the mode encoding constants, the FSM state encoding and the mode-to-rank function.
REQ-033 Sub-module pmu_vote_reduce SHALL implement the combinational max-rank reduction of REQ-017.

Verification
REQ-034 Directed scenarios:
- Reset -> granted=00, perm_active_req=1, busy=0, err=0.
- Vote0 MEASURE, ack after 3 cycles -> measure_req asserted 1 cycle after the vote, granted=01 the cycle after ack, busy low.
- Granted ACTIVE, all votes drop, holdoff=5 -> HOLD 5 cycles, then stdby... no: then sleep_req asserted; STANDBY vote in cycle 2 restarts the count.
- Holdoff=5, re-raise ACTIVE in cycle 3 of HOLD -> back to IDLE, no request change, granted=00.
- TIMEOUT_EN, timeout=10, ack never given -> err=1 after 10 cycles, granted unchanged; err_clr and timeout in the same cycle -> err stays 1.
- Four simultaneous votes {11,10,00,01} -> target MEASURE; perm_rstb low in WAIT -> active_req=1, busy=0.

Source files
------------

// File: rtl/pmu_pkg.sv
// pmu_pkg: shared PMU power-mode encoding, arbiter FSM state encoding and
// mode <-> rank helpers used by pmu_mode_arbiter and pmu_vote_reduce.
package pmu_pkg;

    localparam logic [1:0] MODE_ACTIVE     = 2'b00;
    localparam logic [1:0] MODE_MEASURE    = 2'b01;
    localparam logic [1:0] MODE_STANDBY    = 2'b10;
    localparam logic [1:0] MODE_DEEP_SLEEP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    // Priority rank of a mode: MEASURE(3) > ACTIVE(2) > STANDBY(1) > DEEP_SLEEP(0)
    function automatic logic [1:0] mode_rank(input logic [1:0] mode);
        logic [1:0] rank;
        case (mode)
            MODE_MEASURE: rank = 2'd3;
            MODE_ACTIVE:  rank = 2'd2;
            MODE_STANDBY: rank = 2'd1;
            default:      rank = 2'd0;
        endcase
        return rank;
    endfunction

    // Inverse of mode_rank
    function automatic logic [1:0] rank_mode(input logic [1:0] rank);
        logic [1:0] mode;
        case (rank)
            2'd3:    mode = MODE_MEASURE;
            2'd2:    mode = MODE_ACTIVE;
            2'd1:    mode = MODE_STANDBY;
            default: mode = MODE_DEEP_SLEEP;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/pmu_vote_reduce.sv
// pmu_vote_reduce: combinational max-rank reduction over requester votes.
// Ports:
//   vote_valid_i    per-requester vote valid
//   vote_mode_i     per-requester mode, requester i at [2i+1:2i]
//   target_mode_o_c highest-ranked valid mode, DEEP_SLEEP when no vote
module pmu_vote_reduce
    import pmu_pkg::*;
#(
    parameter int unsigned NB_REQ = 4
) (
    input  logic [NB_REQ-1:0]   vote_valid_i,
    input  logic [2*NB_REQ-1:0] vote_mode_i,
    output logic [1:0]          target_mode_o_c
);

    logic [1:0] best_rank;

    // Rank 0 is DEEP_SLEEP, so an empty vote set falls out naturally
    always_comb begin
        best_rank = 2'd0;
        for (int i = 0; i < int'(NB_REQ); i++) begin
            if (vote_valid_i[i] && (mode_rank(vote_mode_i[2*i +: 2]) > best_rank)) begin
                best_rank = mode_rank(vote_mode_i[2*i +: 2]);
            end
        end
        target_mode_o_c = rank_mode(best_rank);
    end

endmodule

// File: rtl/pmu_mode_arbiter.sv
// pmu_mode_arbiter: arbitrates per-requester power-mode votes into a single
// PMU mode request. Upgrades are requested immediately, downgrades only after
// the target has been stable for perm_holdoff_limit cycles. Exactly one
// perm_*_req level is high: the mode in flight, else the granted mode.
// Ports:
//   perm_clk / perm_rstb                  clock, async active-low reset
//   perm_vote_valid / perm_vote_mode      requester votes
//   perm_holdoff_limit                    downgrade hold-off (cycles)
//   perm_timeout_limit                    ack timeout (cycles), 0 = off
//   perm_{sleep,stdby,active,measure}_req level requests to the PMU
//   perm_{sleep,stdby,active,measure}_ack PMU acknowledges
//   perm_granted_mode                     last acknowledged mode
//   perm_busy                             in hold-off or awaiting ack
//   perm_timeout_err / perm_err_clr       sticky timeout flag and its clear
// Build option: PMU_MODE_ARB_TIMEOUT_EN enables the acknowledge timeout;
// without it WAIT never times out and perm_timeout_err stays 0.
module pmu_mode_arbiter
    import pmu_pkg::*;
#(
    parameter int unsigned NB_REQ    = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                  perm_clk,
    input  logic                  perm_rstb,
    input  logic [NB_REQ-1:0]     perm_vote_valid,
    input  logic [2*NB_REQ-1:0]   perm_vote_mode,
    input  logic [CNT_WIDTH-1:0]  perm_holdoff_limit,
    input  logic [CNT_WIDTH-1:0]  perm_timeout_limit,
    output logic                  perm_sleep_req,
    output logic                  perm_stdby_req,
    output logic                  perm_active_req,
    output logic                  perm_measure_req,
    input  logic                  perm_sleep_ack,
    input  logic                  perm_stdby_ack,
    input  logic                  perm_active_ack,
    input  logic                  perm_measure_ack,
    output logic [1:0]            perm_granted_mode,
    output logic                  perm_busy,
    output logic                  perm_timeout_err,
    input  logic                  perm_err_clr
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    arb_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic [1:0]           req_mode_q, req_mode_d;
    logic [1:0]           granted_q, granted_d;
    logic [1:0]           hold_tgt_q, hold_tgt_d;
    logic [3:0]           req_q, req_d;
    logic                 busy_q, err_q, err_d;
    logic [1:0]           target_c, out_mode_c, tgt_rank_c, gr_rank_c;
    logic                 ack_c, timeout_c, set_err_c;

    pmu_vote_reduce #(.NB_REQ(NB_REQ)) u_vote_reduce (
        .vote_valid_i    (perm_vote_valid),
        .vote_mode_i     (perm_vote_mode),
        .target_mode_o_c (target_c)
    );

    assign tgt_rank_c = mode_rank(target_c);
    assign gr_rank_c  = mode_rank(granted_q);
    assign cnt_inc_c  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // Ack matching the mode currently in flight
    always_comb begin
        case (req_mode_q)
            MODE_ACTIVE:  ack_c = perm_active_ack;
            MODE_MEASURE: ack_c = perm_measure_ack;
            MODE_STANDBY: ack_c = perm_stdby_ack;
            default:      ack_c = perm_sleep_ack;
        endcase
    end

`ifdef PMU_MODE_ARB_TIMEOUT_EN
    assign timeout_c = (perm_timeout_limit != '0) && (cnt_q == perm_timeout_limit);
`else
    logic unused_timeout_cfg;
    assign timeout_c          = 1'b0;
    assign unused_timeout_cfg = ^{perm_timeout_limit, perm_err_clr};
`endif

    // Next-state, counter and request decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_mode_d = req_mode_q;
        granted_d  = granted_q;
        hold_tgt_d = hold_tgt_q;
        set_err_c  = 1'b0;
        req_d      = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (tgt_rank_c > gr_rank_c || (tgt_rank_c < gr_rank_c && perm_holdoff_limit == '0)) begin
                    state_d    = ST_WAIT;
                    req_mode_d = target_c;
                    cnt_d      = '0;
                end else if (tgt_rank_c < gr_rank_c) begin
                    state_d    = ST_HOLD;
                    hold_tgt_d = target_c;
                    cnt_d      = '0;
                end
            end
            ST_HOLD: begin
                if (tgt_rank_c > gr_rank_c) begin
                    state_d    = ST_WAIT;
                    req_mode_d = target_c;
                    cnt_d      = '0;
                end else if (tgt_rank_c == gr_rank_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (target_c != hold_tgt_q) begin
                    // A different downgrade target restarts the hold-off
                    hold_tgt_d = target_c;
                    cnt_d      = '0;
                end else if (cnt_q == perm_holdoff_limit - CNT_WIDTH'(1)) begin
                    state_d    = ST_WAIT;
                    req_mode_d = target_c;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ST_WAIT: begin
                if (ack_c) begin
                    state_d   = ST_IDLE;
                    granted_d = req_mode_q;
                    cnt_d     = '0;
                end else if (timeout_c) begin
                    state_d   = ST_IDLE;
                    set_err_c = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef PMU_MODE_ARB_TIMEOUT_EN
        err_d = set_err_c | (err_q & ~perm_err_clr);
`else
        err_d = 1'b0;
`endif

        // Request bit index equals the mode encoding
        out_mode_c        = (state_d == ST_WAIT) ? req_mode_d : granted_d;
        req_d[out_mode_c] = 1'b1;
    end

    // State and output registers
    always_ff @(posedge perm_clk or negedge perm_rstb) begin
        if (!perm_rstb) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_mode_q <= MODE_ACTIVE;
            granted_q  <= MODE_ACTIVE;
            hold_tgt_q <= MODE_ACTIVE;
            req_q      <= 4'b0001;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_mode_q <= req_mode_d;
            granted_q  <= granted_d;
            hold_tgt_q <= hold_tgt_d;
            req_q      <= req_d;
            busy_q     <= (state_d != ST_IDLE);
            err_q      <= err_d;
        end
    end

    assign perm_active_req   = req_q[0];
    assign perm_measure_req  = req_q[1];
    assign perm_stdby_req    = req_q[2];
    assign perm_sleep_req    = req_q[3];
    assign perm_granted_mode = granted_q;
    assign perm_busy         = busy_q;
    assign perm_timeout_err  = err_q;

endmodule

// File: tb/tb_pmu_mode_arbiter.sv
// tb_pmu_mode_arbiter: directed scenarios plus randomized votes/acks checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_pmu_mode_arbiter;

    localparam int unsigned NB_REQ    = 4;
    localparam int unsigned CNT_WIDTH = 8;
`ifdef PMU_MODE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk  = 1'b0;
    logic                 rstb = 1'b0;
    logic [NB_REQ-1:0]    vote_valid = '0;
    logic [2*NB_REQ-1:0]  vote_mode  = '0;
    logic [CNT_WIDTH-1:0] holdoff    = '0;
    logic [CNT_WIDTH-1:0] tlimit     = '0;
    logic sleep_req, stdby_req, active_req, measure_req;
    logic sleep_ack = 1'b0, stdby_ack = 1'b0, active_ack = 1'b0, measure_ack = 1'b0;
    logic [1:0] granted;
    logic busy, terr;
    logic err_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pmu_mode_arbiter #(.NB_REQ(NB_REQ), .CNT_WIDTH(CNT_WIDTH)) dut (
        .perm_clk           (clk),
        .perm_rstb          (rstb),
        .perm_vote_valid    (vote_valid),
        .perm_vote_mode     (vote_mode),
        .perm_holdoff_limit (holdoff),
        .perm_timeout_limit (tlimit),
        .perm_sleep_req     (sleep_req),
        .perm_stdby_req     (stdby_req),
        .perm_active_req    (active_req),
        .perm_measure_req   (measure_req),
        .perm_sleep_ack     (sleep_ack),
        .perm_stdby_ack     (stdby_ack),
        .perm_active_ack    (active_ack),
        .perm_measure_ack   (measure_ack),
        .perm_granted_mode  (granted),
        .perm_busy          (busy),
        .perm_timeout_err   (terr),
        .perm_err_clr       (err_clr)
    );

    // ---------------- behavioural model ----------------
    // rank indexed by mode code: 00 ACTIVE=2, 01 MEASURE=3, 10 STANDBY=1, 11 SLEEP=0
    int         rank_of [4] = '{2, 3, 1, 0};
    int         m_phase;            // 0 idle, 1 holding off, 2 awaiting ack
    logic [1:0] m_gr, m_req, m_last;
    logic [7:0] m_cnt;
    logic       m_err;

    function automatic logic [1:0] model_target();
        int         best = 0;
        logic [1:0] m    = 2'b11;
        logic [1:0] v;
        for (int i = 0; i < int'(NB_REQ); i++) begin
            v = vote_mode[2*i +: 2];
            if (vote_valid[i] && rank_of[v] > best) begin
                best = rank_of[v];
                m    = v;
            end
        end
        return m;
    endfunction

    function automatic logic model_ack(input logic [1:0] m);
        logic [3:0] acks;
        acks = {sleep_ack, stdby_ack, measure_ack, active_ack};
        return acks[m];
    endfunction

    task automatic model_reset();
        m_phase = 0; m_gr = 2'b00; m_req = 2'b00; m_last = 2'b00; m_cnt = 8'd0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0] t;
        int         tr, gr;
        logic       hit;
        t   = model_target();
        tr  = rank_of[t];
        gr  = rank_of[m_gr];
        hit = 1'b0;
        case (m_phase)
            0: begin
                if (tr > gr || (tr < gr && holdoff == 8'd0)) begin
                    m_phase = 2; m_req = t; m_cnt = 8'd0;
                end else if (tr < gr) begin
                    m_phase = 1; m_last = t; m_cnt = 8'd0;
                end
            end
            1: begin
                if (tr > gr) begin
                    m_phase = 2; m_req = t; m_cnt = 8'd0;
                end else if (tr == gr) begin
                    m_phase = 0; m_cnt = 8'd0;
                end else if (t != m_last) begin
                    m_last = t; m_cnt = 8'd0;
                end else if (m_cnt == 8'(holdoff - 8'd1)) begin
                    m_phase = 2; m_req = t; m_cnt = 8'd0;
                end else if (m_cnt != 8'hFF) begin
                    m_cnt = m_cnt + 8'd1;
                end
            end
            default: begin
                if (model_ack(m_req)) begin
                    m_gr = m_req; m_phase = 0; m_cnt = 8'd0;
                end else if (TO_EN && tlimit != 8'd0 && m_cnt == tlimit) begin
                    hit = 1'b1; m_phase = 0; m_cnt = 8'd0;
                end else if (m_cnt != 8'hFF) begin
                    m_cnt = m_cnt + 8'd1;
                end
            end
        endcase
        if (hit)                 m_err = 1'b1;
        else if (TO_EN && err_clr) m_err = 1'b0;
    endtask

    // Advance one clock; inputs are sampled by DUT and model at the same edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        vote_valid = 4'b0001; vote_mode = '0; holdoff = '0; tlimit = '0; err_clr = 1'b0;
        {sleep_ack, stdby_ack, active_ack, measure_ack} = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstb = 1'b0;
        vote_valid = 4'b0001; vote_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (granted !== 2'b00) $display("FAIL reset_granted: got %b want 00", granted); else n_pass++;
        n_checks++; if ({sleep_req, stdby_req, active_req, measure_req} !== 4'b0010)
            $display("FAIL reset_req: got %b want 0010", {sleep_req, stdby_req, active_req, measure_req}); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (terr !== 1'b0) $display("FAIL reset_err: got %b want 0", terr); else n_pass++;
        rstb = 1'b1;
        model_reset();
    endtask

    task automatic test_upgrade();
        do_reset();
        vote_mode[1:0] = 2'b01;
        tick();
        n_checks++; if ({measure_req, active_req, busy, granted} !== 5'b10100)
            $display("FAIL upgrade_req: got %b want 10100", {measure_req, active_req, busy, granted}); else n_pass++;
        tick(); tick();
        n_checks++; if ({measure_req, busy} !== 2'b11) $display("FAIL upgrade_wait: got %b want 11", {measure_req, busy}); else n_pass++;
        measure_ack = 1'b1;
        tick();
        measure_ack = 1'b0;
        n_checks++; if ({granted, busy, measure_req, active_req} !== 5'b01010)
            $display("FAIL upgrade_grant: got %b want 01010", {granted, busy, measure_req, active_req}); else n_pass++;
    endtask

    task automatic test_holdoff();
        do_reset();
        holdoff = 8'd5; vote_valid = '0;
        repeat (5) tick();
        n_checks++; if ({busy, active_req, sleep_req} !== 3'b110)
            $display("FAIL hold_5: got %b want 110", {busy, active_req, sleep_req}); else n_pass++;
        tick();
        n_checks++; if ({sleep_req, active_req} !== 2'b10)
            $display("FAIL hold_sleep_req: got %b want 10", {sleep_req, active_req}); else n_pass++;
        sleep_ack = 1'b1;
        tick();
        sleep_ack = 1'b0;
        n_checks++; if ({granted, busy} !== 3'b110) $display("FAIL hold_grant: got %b want 110", {granted, busy}); else n_pass++;

        // A STANDBY vote arriving mid hold-off restarts the count
        do_reset();
        holdoff = 8'd5; vote_valid = '0;
        tick(); tick();
        vote_valid = 4'b0001; vote_mode[1:0] = 2'b10;
        repeat (5) tick();
        n_checks++; if ({stdby_req, busy} !== 2'b01) $display("FAIL hold_restart: got %b want 01", {stdby_req, busy}); else n_pass++;
        tick();
        n_checks++; if ({stdby_req, active_req} !== 2'b10) $display("FAIL hold_stdby_req: got %b want 10", {stdby_req, active_req}); else n_pass++;
        stdby_ack = 1'b1;
        tick();
        stdby_ack = 1'b0;
        n_checks++; if (granted !== 2'b10) $display("FAIL hold_stdby_grant: got %b want 10", granted); else n_pass++;
    endtask

    task automatic test_reraise();
        do_reset();
        holdoff = 8'd5; vote_valid = '0;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL reraise_hold: got %b want 1", busy); else n_pass++;
        vote_valid = 4'b0001; vote_mode[1:0] = 2'b00;
        tick();
        n_checks++; if ({busy, active_req, granted} !== 4'b0100)
            $display("FAIL reraise_idle: got %b want 0100", {busy, active_req, granted}); else n_pass++;
        repeat (4) tick();
        n_checks++; if ({sleep_req, active_req, busy, granted} !== 5'b01000)
            $display("FAIL reraise_stable: got %b want 01000", {sleep_req, active_req, busy, granted}); else n_pass++;
    endtask

    task automatic test_four_votes();
        do_reset();
        vote_valid = 4'hF;
        vote_mode  = {2'b01, 2'b00, 2'b10, 2'b11};
        tick();
        n_checks++; if ({measure_req, busy} !== 2'b11) $display("FAIL four_target: got %b want 11", {measure_req, busy}); else n_pass++;
        // Target changes are ignored while awaiting the ack
        vote_valid = 4'b0001;
        repeat (3) tick();
        n_checks++; if ({measure_req, sleep_req} !== 2'b10)
            $display("FAIL wait_ignore: got %b want 10", {measure_req, sleep_req}); else n_pass++;
        rstb = 1'b0;
        #1;
        n_checks++; if ({measure_req, active_req, busy, granted} !== 5'b01000)
            $display("FAIL wait_reset: got %b want 01000", {measure_req, active_req, busy, granted}); else n_pass++;
        do_reset();
    endtask

`ifdef PMU_MODE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        tlimit = 8'd10; vote_mode[1:0] = 2'b01;
        repeat (11) tick();
        n_checks++; if ({terr, measure_req, busy} !== 3'b011)
            $display("FAIL to_before: got %b want 011", {terr, measure_req, busy}); else n_pass++;
        tick();
        n_checks++; if ({terr, granted, busy, active_req} !== 5'b10001)
            $display("FAIL to_hit: got %b want 10001", {terr, granted, busy, active_req}); else n_pass++;
        tick();
        n_checks++; if ({measure_req, busy} !== 2'b11) $display("FAIL to_retry: got %b want 11", {measure_req, busy}); else n_pass++;
        repeat (10) tick();
        err_clr = 1'b1;
        tick();
        n_checks++; if (terr !== 1'b1) $display("FAIL to_set_wins: got %b want 1", terr); else n_pass++;
        tick();
        err_clr = 1'b0;
        n_checks++; if (terr !== 1'b0) $display("FAIL to_clear: got %b want 0", terr); else n_pass++;
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        tlimit = 8'd3; vote_mode[1:0] = 2'b01;
        for (int i = 0; i < 20; i++) begin
            err_clr = i[0];
            tick();
        end
        err_clr = 1'b0;
        n_checks++; if ({terr, measure_req, busy, granted} !== 5'b01100)
            $display("FAIL no_timeout: got %b want 01100", {terr, measure_req, busy, granted}); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [1:0] em;
        logic [8:0] exp_v, got_v;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            holdoff = 8'($urandom_range(0, 4));
            tlimit  = 8'($urandom_range(0, 6));
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    vote_valid = 4'($urandom);
                    vote_mode  = 8'($urandom);
                end
                sleep_ack   = ($urandom_range(0, 3) == 0);
                stdby_ack   = ($urandom_range(0, 3) == 0);
                active_ack  = ($urandom_range(0, 3) == 0);
                measure_ack = ($urandom_range(0, 3) == 0);
                err_clr     = ($urandom_range(0, 7) == 0);
                tick();
                em    = (m_phase == 2) ? m_req : m_gr;
                exp_v = {m_gr, em == 2'b11, em == 2'b10, em == 2'b00, em == 2'b01, m_phase != 0, m_err};
                got_v = {granted, sleep_req, stdby_req, active_req, measure_req, busy, terr};
                n_checks++;
                if (got_v !== exp_v)
                    $display("FAIL random seg%0d cyc%0d: got %b want %b (gr,sl,sb,ac,me,busy,err)", seg, c, got_v, exp_v);
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_upgrade();
        test_holdoff();
        test_reraise();
        test_four_votes();
`ifdef PMU_MODE_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
